// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH-channel programmable clock divider / tick generator.
// Each channel divides clk by a runtime-loadable half-period d and emits a
// one-cycle registered tick every d enabled cycles plus a 50%-duty square
// wave sq that toggles on each tick. sq is a data signal, never a clock.
// Optional feature: define CLKDIV_READBACK_EN to add the rd_ch/rd_div
// divisor readback port (registered, 1-cycle latency).
module clk_div_multi #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned CW          = 25,
    parameter int unsigned DEFAULT_DIV = 25000000,
    localparam int unsigned SW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] en,
    input  logic           sync,
    input  logic           load,
    input  logic [SW-1:0]  load_ch,
    input  logic [CW-1:0]  load_div,
    output logic [NCH-1:0] tick,
`ifdef CLKDIV_READBACK_EN
    input  logic [SW-1:0]  rd_ch,
    output logic [CW-1:0]  rd_div,
`endif
    output logic [NCH-1:0] sq
);

    // Per-channel state
    logic [CW-1:0]  r_div [NCH];
    logic [CW-1:0]  r_cnt [NCH];
    logic [NCH-1:0] r_tick;
    logic [NCH-1:0] r_sq;

    // Per-channel decode
    logic [NCH-1:0] w_load_sel;
    logic [CW-1:0]  w_lim [NCH];
    logic [NCH-1:0] w_wrap;

    // Load select, terminal count (d-1 with d=0 treated as 1) and wrap flag.
    // Matching load_ch against each in-range index means an index >= NCH
    // selects nothing, so out-of-range loads fall away without a compare.
    always_comb begin
        w_load_sel = '0;
        w_lim      = '{default: '0};
        w_wrap     = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            w_load_sel[c] = load && (load_ch == SW'(c));
            w_lim[c]      = (r_div[c] == '0) ? '0 : (r_div[c] - CW'(1));
            // >= rather than == recovers a counter left above a smaller divisor
            w_wrap[c]     = (r_cnt[c] >= w_lim[c]);
        end
    end

    // Divisor registers: written by load on the selected channel only; a
    // simultaneous sync does not block the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                r_div[c] <= CW'(DEFAULT_DIV);
            end
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (w_load_sel[c]) begin
                    r_div[c] <= load_div;
                end
            end
        end
    end

    // Counter, tick and square wave per channel; priority sync > load > count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                r_cnt[c] <= '0;
            end
            r_tick <= '0;
            r_sq   <= '0;
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (sync) begin
                    r_cnt[c]  <= '0;
                    r_tick[c] <= 1'b0;
                    r_sq[c]   <= 1'b0;
                end else if (w_load_sel[c]) begin
                    r_cnt[c]  <= '0;
                    r_tick[c] <= 1'b0;
                end else if (en[c]) begin
                    if (w_wrap[c]) begin
                        r_cnt[c]  <= '0;
                        r_tick[c] <= 1'b1;
                        r_sq[c]   <= ~r_sq[c];
                    end else begin
                        r_cnt[c]  <= r_cnt[c] + CW'(1);
                        r_tick[c] <= 1'b0;
                    end
                end else begin
                    r_tick[c] <= 1'b0;
                end
            end
        end
    end

    assign tick = r_tick;
    assign sq   = r_sq;

`ifdef CLKDIV_READBACK_EN
    logic [CW-1:0] w_rd_val;
    logic [CW-1:0] r_rd_div;

    // Readback mux; an index >= NCH matches no channel and reads 0
    always_comb begin
        w_rd_val = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (rd_ch == SW'(c)) begin
                w_rd_val = r_div[c];
            end
        end
    end

    // Registered readback; samples the pre-load divisor on a same-cycle load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_div <= '0;
        end else begin
            r_rd_div <= w_rd_val;
        end
    end

    assign rd_div = r_rd_div;
`else
    // Readback disabled: no rd_ch/rd_div ports and no readback logic.
`endif

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (NCH=4, DEFAULT_DIV=5) plus
// a small NCH=3 instance for the out-of-range load index.
module tb_clk_div_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] en = 4'hF;
    logic       sync = 1'b0;
    logic       load = 1'b0;
    logic [1:0] load_ch = '0;
    logic [7:0] load_div = '0;
    logic [3:0] tick;
    logic [3:0] sq;

    logic [2:0] en3 = 3'b111;
    logic       sync3 = 1'b0;
    logic       load3 = 1'b0;
    logic [1:0] load_ch3 = '0;
    logic [7:0] load_div3 = '0;
    logic [2:0] tick3;
    logic [2:0] sq3;

`ifdef CLKDIV_READBACK_EN
    logic [1:0] rd_ch = '0;
    logic [1:0] rd_ch3 = '0;
    logic [7:0] rd_div;
    logic [7:0] rd_div3;
`endif

    clk_div_multi #(.NCH(4), .CW(8), .DEFAULT_DIV(5)) u_dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .load(load),
        .load_ch(load_ch), .load_div(load_div), .tick(tick),
`ifdef CLKDIV_READBACK_EN
        .rd_ch(rd_ch), .rd_div(rd_div),
`endif
        .sq(sq)
    );

    clk_div_multi #(.NCH(3), .CW(8), .DEFAULT_DIV(2)) u_dut3 (
        .clk(clk), .rst(rst), .en(en3), .sync(sync3), .load(load3),
        .load_ch(load_ch3), .load_div(load_div3), .tick(tick3),
`ifdef CLKDIV_READBACK_EN
        .rd_ch(rd_ch3), .rd_div(rd_div3),
`endif
        .sq(sq3)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   k = 0;           // rising edges since reset release
    int   base [4];        // edge index at which each channel was last cleared
    int   dv [4];          // effective divisor per channel
    logic sq0 [4];         // sq value at the last clear

    // Expected tick: high after every d-th enabled edge since the last clear
    function automatic logic [3:0] exp_tick();
        logic [3:0] v;
        v = '0;
        for (int c = 0; c < 4; c++)
            if (en[c] && (k - base[c]) > 0 && ((k - base[c]) % dv[c]) == 0) v[c] = 1'b1;
        return v;
    endfunction

    // Expected sq: toggled once per completed half-period since the last clear
    function automatic logic [3:0] exp_sq();
        logic [3:0] v;
        for (int c = 0; c < 4; c++)
            v[c] = sq0[c] ^ ((((k - base[c]) / dv[c]) % 2) == 1);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            base[c] = k;
            dv[c]   = 5;
            sq0[c]  = 1'b0;
        end
    endtask

    // Issue a single-cycle load; model records the clear at the load edge
    task automatic do_load(input int c, input int v);
        logic [3:0] s;
        s        = exp_sq();
        load     = 1'b1;
        load_ch  = 2'(c);
        load_div = 8'(v);
        step();
        load     = 1'b0;
        base[c]  = k;
        sq0[c]   = s[c];
        dv[c]    = (v == 0) ? 1 : v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (tick !== 4'h0) begin failures++; $display("FAIL reset_tick got=%h want=0", tick); end
        checks++;
        if (sq !== 4'h0) begin failures++; $display("FAIL reset_sq got=%h want=0", sq); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0;
        model_reset();
    endtask

    task automatic test_divide();
        for (int n = 0; n < 20; n++) begin
            step();
            checks++;
            if (tick !== exp_tick()) begin failures++; $display("FAIL divide_tick edge=%0d got=%h want=%h", k, tick, exp_tick()); end
            checks++;
            if (sq !== exp_sq()) begin failures++; $display("FAIL divide_sq edge=%0d got=%h want=%h", k, sq, exp_sq()); end
        end
    endtask

    task automatic test_load();
        for (int n = 0; n < 2; n++) begin
            step();
            checks++;
            if (tick !== exp_tick()) begin failures++; $display("FAIL load_pre_tick edge=%0d got=%h want=%h", k, tick, exp_tick()); end
        end
`ifdef CLKDIV_READBACK_EN
        rd_ch = 2'd2;
`endif
        do_load(2, 3);
        checks++;
        if (tick !== exp_tick()) begin failures++; $display("FAIL load_edge_tick got=%h want=%h", tick, exp_tick()); end
        checks++;
        if (sq !== exp_sq()) begin failures++; $display("FAIL load_edge_sq got=%h want=%h", sq, exp_sq()); end
`ifdef CLKDIV_READBACK_EN
        checks++;
        if (rd_div !== 8'd5) begin failures++; $display("FAIL readback_old got=%0d want=5", rd_div); end
`endif
        for (int n = 0; n < 15; n++) begin
            step();
`ifdef CLKDIV_READBACK_EN
            if (n == 0) begin
                checks++;
                if (rd_div !== 8'd3) begin failures++; $display("FAIL readback_new got=%0d want=3", rd_div); end
            end
`endif
            checks++;
            if (tick !== exp_tick()) begin failures++; $display("FAIL load_tick edge=%0d got=%h want=%h", k, tick, exp_tick()); end
            checks++;
            if (sq !== exp_sq()) begin failures++; $display("FAIL load_sq edge=%0d got=%h want=%h", k, sq, exp_sq()); end
        end
    endtask

    task automatic test_enable_freeze();
        en = 4'b1101;
        for (int n = 0; n < 7; n++) begin
            step();
            base[1]++;
            checks++;
            if (tick !== exp_tick()) begin failures++; $display("FAIL freeze_tick edge=%0d got=%h want=%h", k, tick, exp_tick()); end
            checks++;
            if (sq !== exp_sq()) begin failures++; $display("FAIL freeze_sq edge=%0d got=%h want=%h", k, sq, exp_sq()); end
        end
        en = 4'hF;
        for (int n = 0; n < 12; n++) begin
            step();
            checks++;
            if (tick !== exp_tick()) begin failures++; $display("FAIL resume_tick edge=%0d got=%h want=%h", k, tick, exp_tick()); end
            checks++;
            if (sq !== exp_sq()) begin failures++; $display("FAIL resume_sq edge=%0d got=%h want=%h", k, sq, exp_sq()); end
        end
    endtask

    task automatic test_div_zero_one();
        do_load(3, 0);
        checks++;
        if (tick !== exp_tick()) begin failures++; $display("FAIL div0_edge_tick got=%h want=%h", tick, exp_tick()); end
        do_load(0, 1);
        checks++;
        if (tick !== exp_tick()) begin failures++; $display("FAIL div1_edge_tick got=%h want=%h", tick, exp_tick()); end
        for (int n = 0; n < 6; n++) begin
            step();
            checks++;
            if (tick !== exp_tick()) begin failures++; $display("FAIL div01_tick edge=%0d got=%h want=%h", k, tick, exp_tick()); end
            checks++;
            if (sq !== exp_sq()) begin failures++; $display("FAIL div01_sq edge=%0d got=%h want=%h", k, sq, exp_sq()); end
        end
    endtask

    task automatic test_sync_load();
        do_load(2, 5);
        do_load(3, 5);
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if (sq !== exp_sq()) begin failures++; $display("FAIL presync_sq edge=%0d got=%h want=%h", k, sq, exp_sq()); end
        end
        sync     = 1'b1;
        load     = 1'b1;
        load_ch  = 2'd0;
        load_div = 8'd4;
        step();
        sync = 1'b0;
        load = 1'b0;
        for (int c = 0; c < 4; c++) begin
            base[c] = k;
            sq0[c]  = 1'b0;
        end
        dv[0] = 4;
        checks++;
        if (tick !== 4'h0) begin failures++; $display("FAIL sync_edge_tick got=%h want=0", tick); end
        checks++;
        if (sq !== 4'h0) begin failures++; $display("FAIL sync_edge_sq got=%h want=0", sq); end
        for (int n = 0; n < 12; n++) begin
            step();
            checks++;
            if (tick !== exp_tick()) begin failures++; $display("FAIL sync_tick edge=%0d got=%h want=%h", k, tick, exp_tick()); end
            checks++;
            if (sq !== exp_sq()) begin failures++; $display("FAIL sync_sq edge=%0d got=%h want=%h", k, sq, exp_sq()); end
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        #1;
        checks++;
        if (tick !== 4'h0) begin failures++; $display("FAIL async_rst_tick got=%h want=0", tick); end
        checks++;
        if (sq !== 4'h0) begin failures++; $display("FAIL async_rst_sq got=%h want=0", sq); end
        @(posedge clk);
        #1;
        k++;
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 11; n++) begin
            step();
            checks++;
            if (tick !== exp_tick()) begin failures++; $display("FAIL post_rst_tick edge=%0d got=%h want=%h", k, tick, exp_tick()); end
            checks++;
            if (sq !== exp_sq()) begin failures++; $display("FAIL post_rst_sq edge=%0d got=%h want=%h", k, sq, exp_sq()); end
        end
    endtask

    task automatic test_out_of_range();
        logic [2:0] et;
        logic [2:0] es;
        sync3 = 1'b1;
        step();
        sync3 = 1'b0;
        checks++;
        if (sq3 !== 3'b000) begin failures++; $display("FAIL oor_sync_sq got=%b want=000", sq3); end
        load3     = 1'b1;
        load_ch3  = 2'd3;
        load_div3 = 8'd0;
`ifdef CLKDIV_READBACK_EN
        rd_ch3 = 2'd3;
`endif
        for (int j = 1; j <= 9; j++) begin
            step();
            load3 = 1'b0;
`ifdef CLKDIV_READBACK_EN
            if (j == 1) begin
                checks++;
                if (rd_div3 !== 8'd0) begin failures++; $display("FAIL oor_readback got=%0d want=0", rd_div3); end
            end
`endif
            et = ((j % 2) == 0) ? 3'b111 : 3'b000;
            es = (((j / 2) % 2) == 1) ? 3'b111 : 3'b000;
            checks++;
            if (tick3 !== et) begin failures++; $display("FAIL oor_tick j=%0d got=%b want=%b", j, tick3, et); end
            checks++;
            if (sq3 !== es) begin failures++; $display("FAIL oor_sq j=%0d got=%b want=%b", j, sq3, es); end
        end
    endtask

    initial begin
        test_reset();
        test_divide();
        test_load();
        test_enable_freeze();
        test_div_zero_one();
        test_sync_load();
        test_reset_mid();
        test_out_of_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
